// File: rtl/gshare_spec_predictor_if.sv
// Fetch/commit/flush signal bundle for gshare_spec_predictor.
// The master side drives requests and commits; the slave side is the predictor.
interface gshare_spec_predictor_if #(
  parameter int GHR_WIDTH = 8
);
  logic                 fetch_valid;
  logic [31:0]          fetch_pc;
  logic                 fetch_is_br;
  logic                 pred_valid;
  logic                 pred_taken;
  logic [GHR_WIDTH-1:0] pred_ghr;
  logic                 ret_valid;
  logic [31:0]          ret_pc;
  logic                 ret_taken;
  logic [GHR_WIDTH-1:0] ret_ghr;
  logic                 ret_mispredict;
  logic                 flush;
  logic [31:0]          br_count;
  logic [31:0]          mispred_count;

  modport master (
    output fetch_valid, fetch_pc, fetch_is_br,
    output ret_valid, ret_pc, ret_taken, ret_ghr, ret_mispredict, flush,
    input  pred_valid, pred_taken, pred_ghr, br_count, mispred_count
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_is_br,
    input  ret_valid, ret_pc, ret_taken, ret_ghr, ret_mispredict, flush,
    output pred_valid, pred_taken, pred_ghr, br_count, mispred_count
  );
endinterface

// File: rtl/gshare_spec_predictor.sv
// gshare predictor with speculative global history, per-prediction snapshots,
// flush repair from the architectural history, and commit-side counters.
module gshare_spec_predictor #(
  parameter int GHR_WIDTH = 8,
  parameter int PHT_INDEX = 10,
  parameter int CTR_WIDTH = 2
) (
  input logic                    clk,
  input logic                    rst,
  gshare_spec_predictor_if.slave bus
);
  localparam int unsigned PHT_DEPTH = 2 ** PHT_INDEX;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = {1'b0, {(CTR_WIDTH-1){1'b1}}};

  logic [CTR_WIDTH-1:0] pht [PHT_DEPTH];
  logic [GHR_WIDTH-1:0] sghr;
  logic [GHR_WIDTH-1:0] aghr;
  logic                 pred_valid_r;
  logic                 pred_taken_r;
  logic [GHR_WIDTH-1:0] pred_ghr_r;
  logic [31:0]          br_count_r;
  logic [31:0]          mispred_count_r;

  logic [PHT_INDEX-1:0] idx_f;
  logic [PHT_INDEX-1:0] idx_r;
  logic [CTR_WIDTH-1:0] ctr_f;
  logic [CTR_WIDTH-1:0] ctr_r;
  logic [CTR_WIDTH-1:0] ctr_r_next;
  logic                 p;
  logic                 fetch_go;
  logic [GHR_WIDTH-1:0] aghr_next;
  logic                 unused_pc_bits;

  // Shift-then-OR keeps GHR_WIDTH = 1 legal (no negative slice).
  function automatic logic [GHR_WIDTH-1:0] shift_in(input logic [GHR_WIDTH-1:0] h,
                                                    input logic b);
    return (h << 1) | GHR_WIDTH'(b);
  endfunction

  assign idx_f    = bus.fetch_pc[PHT_INDEX+1:2] ^ PHT_INDEX'(sghr);
  assign idx_r    = bus.ret_pc[PHT_INDEX+1:2] ^ PHT_INDEX'(bus.ret_ghr);
  assign ctr_f    = pht[idx_f];
  assign ctr_r    = pht[idx_r];
  assign p        = bus.fetch_is_br & ctr_f[CTR_WIDTH-1];
  assign fetch_go = bus.fetch_valid & ~bus.flush;

  assign unused_pc_bits = ^{bus.fetch_pc[31:PHT_INDEX+2], bus.fetch_pc[1:0],
                            bus.ret_pc[31:PHT_INDEX+2], bus.ret_pc[1:0]};

  always_comb begin
    aghr_next = aghr;
    if (bus.ret_valid) aghr_next = shift_in(aghr, bus.ret_taken);
  end

  always_comb begin
    ctr_r_next = ctr_r;
    if (bus.ret_taken) begin
      if (ctr_r != '1) ctr_r_next = ctr_r + CTR_WIDTH'(1);
    end else begin
      if (ctr_r != '0) ctr_r_next = ctr_r - CTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sghr            <= '0;
      aghr            <= '0;
      pred_valid_r    <= 1'b0;
      pred_taken_r    <= 1'b0;
      pred_ghr_r      <= '0;
      br_count_r      <= '0;
      mispred_count_r <= '0;
      for (int unsigned i = 0; i < PHT_DEPTH; i++) pht[PHT_INDEX'(i)] <= CTR_INIT;
    end else begin
      if (bus.ret_valid) begin
        pht[idx_r] <= ctr_r_next;
        aghr       <= aghr_next;
        br_count_r <= br_count_r + 32'd1;
        if (bus.ret_mispredict) mispred_count_r <= mispred_count_r + 32'd1;
      end

      if (bus.flush) sghr <= aghr_next;
      else if (bus.fetch_valid && bus.fetch_is_br) sghr <= shift_in(sghr, p);

      pred_valid_r <= fetch_go;
      if (fetch_go) begin
        pred_taken_r <= p;
        pred_ghr_r   <= sghr;
      end
    end
  end

  assign bus.pred_valid    = pred_valid_r;
  assign bus.pred_taken    = pred_taken_r;
  assign bus.pred_ghr      = pred_ghr_r;
  assign bus.br_count      = br_count_r;
  assign bus.mispred_count = mispred_count_r;
endmodule

// File: tb/tb_gshare_spec_predictor.sv
// Directed bench for gshare_spec_predictor: prediction, training, saturation,
// speculative history, flush repair, read/write collision, counters and reset.
module tb_gshare_spec_predictor;
  localparam int GW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gshare_spec_predictor_if #(.GHR_WIDTH(GW)) bus ();

  gshare_spec_predictor #(
    .GHR_WIDTH(GW),
    .PHT_INDEX(10),
    .CTR_WIDTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pc_of(input logic [9:0] idx, input logic [7:0] s);
    return {20'b0, idx ^ {2'b00, s}, 2'b00};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetch_valid    = 1'b0;
    bus.fetch_pc       = '0;
    bus.fetch_is_br    = 1'b0;
    bus.ret_valid      = 1'b0;
    bus.ret_pc         = '0;
    bus.ret_taken      = 1'b0;
    bus.ret_ghr        = '0;
    bus.ret_mispredict = 1'b0;
    bus.flush          = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc;
    bus.fetch_is_br = 1'b1;
    step();
    idle();
  endtask

  task automatic commit(input logic [31:0] pc, input logic [7:0] ghr,
                        input logic taken, input logic misp);
    bus.ret_valid      = 1'b1;
    bus.ret_pc         = pc;
    bus.ret_ghr        = ghr;
    bus.ret_taken      = taken;
    bus.ret_mispredict = misp;
    step();
    idle();
  endtask

  task automatic check_pred(input string tag, input logic taken, input logic [7:0] ghr);
    check_eq({tag, ".valid"}, {31'b0, bus.pred_valid}, 32'd1);
    check_eq({tag, ".taken"}, {31'b0, bus.pred_taken}, {31'b0, taken});
    check_eq({tag, ".ghr"},   {24'b0, bus.pred_ghr},   {24'b0, ghr});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".valid"},   {31'b0, bus.pred_valid}, 32'd0);
    check_eq({tag, ".taken"},   {31'b0, bus.pred_taken}, 32'd0);
    check_eq({tag, ".ghr"},     {24'b0, bus.pred_ghr},   32'd0);
    check_eq({tag, ".br"},      bus.br_count,            32'd0);
    check_eq({tag, ".mispred"}, bus.mispred_count,       32'd0);
  endtask

  logic [7:0] bits;
  logic [7:0] s;
  logic       want;

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_outputs("reset");

    fetch(32'h100);
    check_pred("first", 1'b0, 8'h00);

    // Train idx 0x40: 01 -> 10 -> 11; the next-cycle fetch sees the update.
    commit(32'h100, 8'h00, 1'b1, 1'b1);
    commit(32'h100, 8'h00, 1'b1, 1'b0);
    fetch(32'h100);
    check_pred("trained", 1'b1, 8'h00);
    fetch(32'h100);
    check_pred("ghr_shift", 1'b0, 8'h01);

    // Four not-taken commits: 11 -> 10 -> 01 -> 00 -> 00.
    repeat (4) commit(32'h100, 8'h00, 1'b0, 1'b0);
    fetch(pc_of(10'h040, 8'h02));
    check_pred("sat_floor", 1'b0, 8'h02);
    commit(32'h100, 8'h00, 1'b1, 1'b0);
    fetch(pc_of(10'h040, 8'h04));
    check_pred("floor_up1", 1'b0, 8'h04);
    commit(32'h100, 8'h00, 1'b1, 1'b0);
    fetch(pc_of(10'h040, 8'h08));
    check_pred("floor_up2", 1'b1, 8'h08);

    fetch(pc_of(10'h040, 8'h11));
    check_pred("b2b_first", 1'b1, 8'h11);
    fetch(pc_of(10'h040, 8'h23));
    check_pred("b2b_second", 1'b1, 8'h23);
    step();
    check_eq("idle_valid", {31'b0, bus.pred_valid}, 32'd0);

    // Architectural history to 0x05 via commits to an unrelated entry.
    bits = 8'h05;
    for (int i = 7; i >= 0; i--) commit(32'h800, 8'h00, bits[i], 1'b0);

    // Speculative history from 0x47 to 0x2B via chosen predictions.
    bits = 8'h2B;
    s    = 8'h47;
    for (int i = 7; i >= 0; i--) begin
      want = bits[i];
      fetch(pc_of(want ? 10'h040 : 10'h300, s));
      check_pred("spec_build", want, s);
      s = {s[6:0], want};
    end

    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc_of(10'h040, 8'h2B);
    bus.fetch_is_br = 1'b1;
    bus.flush       = 1'b1;
    bus.ret_valid   = 1'b1;
    bus.ret_pc      = 32'h800;
    bus.ret_ghr     = 8'h00;
    bus.ret_taken   = 1'b1;
    step();
    idle();
    check_eq("flush_drop", {31'b0, bus.pred_valid}, 32'd0);
    fetch(pc_of(10'h300, 8'h0B));
    check_pred("flush_repair", 1'b0, 8'h0B);

    // Fetch and commit hit idx 0x3F in the same cycle: fetch sees the old 01.
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc_of(10'h03F, 8'h16);
    bus.fetch_is_br = 1'b1;
    bus.ret_valid   = 1'b1;
    bus.ret_pc      = 32'h0FC;
    bus.ret_ghr     = 8'h00;
    bus.ret_taken   = 1'b1;
    step();
    idle();
    check_pred("rw_same", 1'b0, 8'h16);
    fetch(pc_of(10'h03F, 8'h2C));
    check_pred("rw_next", 1'b1, 8'h2C);

    check_eq("br_total", bus.br_count, 32'd18);
    check_eq("mispred_total", bus.mispred_count, 32'd1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("reset2");
    fetch(32'h100);
    check_pred("pht_reinit", 1'b0, 8'h00);

    commit(32'h800, 8'h00, 1'b1, 1'b1);
    commit(32'h800, 8'h00, 1'b1, 1'b0);
    commit(32'h800, 8'h00, 1'b1, 1'b1);
    commit(32'h800, 8'h00, 1'b1, 1'b0);
    commit(32'h800, 8'h00, 1'b1, 1'b0);
    check_eq("br_five", bus.br_count, 32'd5);
    check_eq("mispred_two", bus.mispred_count, 32'd2);
    fetch(32'h800);
    check_pred("pre_rst1", 1'b1, 8'h00);
    fetch(pc_of(10'h200, 8'h01));
    check_pred("pre_rst2", 1'b1, 8'h01);

    // Reset wins over a same-cycle fetch and commit.
    rst             = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc_of(10'h200, 8'h03);
    bus.fetch_is_br = 1'b1;
    bus.ret_valid   = 1'b1;
    bus.ret_pc      = 32'h800;
    bus.ret_taken   = 1'b1;
    bus.ret_mispredict = 1'b1;
    step();
    idle();
    rst = 1'b0;
    check_reset_outputs("reset_mid");
    fetch(32'h800);
    check_pred("post_rst", 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
